// File: rtl/alu4_writeback.sv
// Operand fetch, ALU handshake and writeback sequencer for a 4x4-bit register file; ALU4_WB_OVF_TRAP_EN enables a sticky overflow trap.
// Latency: done is high in the second cycle after the accepting edge (IDLE->EXEC->WB), one instruction per 3 cycles.
// Backpressure: in_ready is high only in IDLE with no trap pending; ena low freezes every state element.
module alu4_writeback #(
    parameter int NREG = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs,
    input  logic       in_imm_sel,
    input  logic [3:0] in_imm,
    input  logic       in_nowb,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic       alu_rin,
    input  logic [3:0] alu_res,
    input  logic       alu_cout,
    input  logic       alu_rout,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_data,
    output logic [3:0] flags,
    output logic       done,
    output logic       trap
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam int FLAG_C  = 0;
    localparam int FLAG_RC = 1;

    logic [1:0] r_state;
    logic [3:0] r_regs [NREG];
    logic [3:0] r_flags;

    logic [3:0] r_alu_op;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic       r_alu_cin;
    logic       r_alu_rin;
    logic [1:0] r_rd;
    logic       r_nowb;

    // Holding registers: ALU outputs captured in EXEC, committed in WB.
    logic [3:0] r_res;
    logic       r_cout;
    logic       r_rout;
    logic       r_v;
    logic       r_z;

    logic       w_trap;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_ovf_block;
    logic       w_reg_write;
    logic [3:0] w_b_operand;

`ifdef ALU4_WB_OVF_TRAP_EN
    logic r_trap;

    // A writing instruction that overflows is squashed and locks the input.
    assign w_ovf_block = r_v & ~r_nowb;
    assign w_trap      = r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (ena && (r_state == S_WB) && w_ovf_block) begin
            r_trap <= 1'b1;
        end
    end
`else
    assign w_ovf_block = 1'b0;
    assign w_trap      = 1'b0;
`endif

    assign w_in_ready  = (r_state == S_IDLE) & ~w_trap;
    assign w_accept    = in_valid & w_in_ready & ena;
    assign w_reg_write = ~r_nowb & ~w_ovf_block;
    assign w_b_operand = in_imm_sel ? in_imm : r_regs[in_rs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_flags   <= 4'd0;
            r_alu_op  <= 4'd0;
            r_alu_a   <= 4'd0;
            r_alu_b   <= 4'd0;
            r_alu_cin <= 1'b0;
            r_alu_rin <= 1'b0;
            r_rd      <= 2'd0;
            r_nowb    <= 1'b0;
            r_res     <= 4'd0;
            r_cout    <= 1'b0;
            r_rout    <= 1'b0;
            r_v       <= 1'b0;
            r_z       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 4'd0;
            end
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_op  <= in_op;
                        r_alu_a   <= r_regs[in_rd];
                        r_alu_b   <= w_b_operand;
                        r_alu_cin <= r_flags[FLAG_C];
                        r_alu_rin <= r_flags[FLAG_RC];
                        r_rd      <= in_rd;
                        r_nowb    <= in_nowb;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res   <= alu_res;
                    r_cout  <= alu_cout;
                    r_rout  <= alu_rout;
                    r_v     <= alu_v;
                    r_z     <= alu_z;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_flags <= {r_z, r_v, r_rout, r_cout};
                    if (w_reg_write) begin
                        r_regs[r_rd] <= r_res;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign done     = (r_state == S_WB) & ena;
    assign trap     = w_trap;
    assign flags    = r_flags;
    assign rd_data  = r_regs[rd_sel];
    assign alu_op   = r_alu_op;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_cin  = r_alu_cin;
    assign alu_rin  = r_alu_rin;

endmodule
